// File: rtl/piso_tx_if.sv
// Handshake and serial-output bundle for piso_tx.
// The master side supplies words; the slave side (the transmitter) drives the serial outputs.
interface piso_tx_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         in_msb_first;
  logic         sdo;
  logic         sdo_valid;
  logic         frame_start;
  logic         frame_end;
  logic         busy;

  modport master (
    output in_valid, in_data, in_msb_first,
    input  in_ready, sdo, sdo_valid, frame_start, frame_end, busy
  );

  modport slave (
    input  in_valid, in_data, in_msb_first,
    output in_ready, sdo, sdo_valid, frame_start, frame_end, busy
  );
endinterface

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with per-word bit order and an inter-frame gap.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_tx #(
  parameter int N   = 8,
  parameter int GAP = 1
) (
  input  logic       clk,
  input  logic       rst,
  piso_tx_if.slave   bus
);
  localparam int CW = (N < 2) ? 1 : $clog2(N);
  localparam int GW = (GAP < 2) ? 1 : $clog2(GAP);
  localparam logic [CW-1:0] CNT_TOP = CW'(N - 1);
  localparam logic [GW-1:0] GAP_TOP = GW'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  shreg_q;
  logic          msb_q;
  logic [CW-1:0] cnt_q;
  logic [GW-1:0] gcnt_q;
  logic          sdo_q;
  logic          sdo_valid_q;
  logic          frame_start_q;
  logic          frame_end_q;
`ifdef PISO_PARITY_EN
  logic          par_q;
  logic          par_ph_q;
`endif

  logic [N-1:0]  shreg_d;
  logic          bit_d;

  // The register always holds the word with the bit currently on sdo at its output end.
  always_comb begin
    shreg_d = msb_q ? {shreg_q[N-2:0], 1'b0} : {1'b0, shreg_q[N-1:1]};
    bit_d   = msb_q ? shreg_d[N-1] : shreg_d[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      shreg_q       <= '0;
      msb_q         <= 1'b0;
      cnt_q         <= '0;
      gcnt_q        <= '0;
      sdo_q         <= 1'b0;
      sdo_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      frame_end_q   <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q         <= 1'b0;
      par_ph_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            state_q       <= S_SHIFT;
            shreg_q       <= bus.in_data;
            msb_q         <= bus.in_msb_first;
            cnt_q         <= CNT_TOP;
            sdo_q         <= bus.in_msb_first ? bus.in_data[N-1] : bus.in_data[0];
            sdo_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            frame_end_q   <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q         <= ^bus.in_data;
            par_ph_q      <= 1'b0;
`endif
          end
        end
        S_SHIFT: begin
          frame_start_q <= 1'b0;
          shreg_q       <= shreg_d;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
            sdo_q <= bit_d;
`ifdef PISO_PARITY_EN
            frame_end_q <= 1'b0;
`else
            frame_end_q <= (cnt_q == CW'(1));
`endif
          end
`ifdef PISO_PARITY_EN
          else if (!par_ph_q) begin
            // One extra cycle carries the parity bit and closes the frame.
            par_ph_q    <= 1'b1;
            sdo_q       <= par_q;
            frame_end_q <= 1'b1;
          end
`endif
          else begin
            sdo_q       <= 1'b0;
            sdo_valid_q <= 1'b0;
            frame_end_q <= 1'b0;
            gcnt_q      <= GAP_TOP;
            state_q     <= (GAP > 0) ? S_GAP : S_IDLE;
          end
        end
        S_GAP: begin
          if (gcnt_q == '0) state_q <= S_IDLE;
          else              gcnt_q  <= gcnt_q - 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready    = (state_q == S_IDLE) & rst;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.sdo         = sdo_q;
  assign bus.sdo_valid   = sdo_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_end   = frame_end_q;
endmodule

// File: tb/tb_piso_tx.sv
// Self-checking bench for piso_tx: directed frames, random frames, back-to-back streaming and resets.
module tb_piso_tx;
  localparam int N   = 8;
  localparam int GAP = 1;
`ifdef PISO_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FL = N + P;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  piso_tx_if #(.N(N)) bus ();
  piso_tx #(.N(N), .GAP(GAP)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Frame bit i as defined by word, order and (optionally) parity.
  function automatic logic exp_bit(input logic [N-1:0] w, input logic msb, input int i);
    if (i >= N) return ^w;
    return msb ? w[N-1-i] : w[i];
  endfunction

  function automatic logic [N:0] exp_frame(input logic [N-1:0] w, input logic msb);
    logic [N:0] f;
    f = '0;
    for (int i = 0; i < FL; i++) f[i] = exp_bit(w, msb, i);
    return f;
  endfunction

  task automatic send_one(input logic [N-1:0] w, input logic msb, output bit ok);
    int t;
    t  = 0;
    ok = 1'b0;
    while (!bus.in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) return;
    bus.in_valid     = 1'b1;
    bus.in_data      = w;
    bus.in_msb_first = msb;
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.in_data      = N'($urandom);
    bus.in_msb_first = 1'($urandom);
    ok = 1'b1;
  endtask

  task automatic capture(output logic [N:0] bits, output int nv, output int spos, output int epos);
    bits = '0;
    nv   = 0;
    spos = -1;
    epos = -1;
    for (int c = 0; c < FL + 4; c++) begin
      if (bus.sdo_valid) begin
        if (nv <= N) bits[nv] = bus.sdo;
        nv++;
      end
      if (bus.frame_start && spos < 0) spos = c;
      if (bus.frame_end && epos < 0) epos = c;
      bus.in_data = N'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h5A;
    bus.in_msb_first = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({bus.sdo_valid, bus.sdo, bus.busy, bus.in_ready, bus.frame_start, bus.frame_end} !== 6'b0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 000000", c,
                 {bus.sdo_valid, bus.sdo, bus.busy, bus.in_ready, bus.frame_start, bus.frame_end});
      end
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: in_ready=%b busy=%b expected 1 0", bus.in_ready, bus.busy);
    end
    @(negedge clk);
  endtask

  task automatic test_lsb_first;
    logic [N-1:0] words [2];
    logic [N-1:0] rxexp [2];
    logic [N:0]   bits;
    logic [N-1:0] rx;
    int nv, spos, epos;
    bit ok;
    words = '{8'hA5, 8'h01};
    rxexp = '{8'hA5, 8'h80};
    for (int k = 0; k < 2; k++) begin
      send_one(words[k], 1'b0, ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL lsb_accept: in_ready never rose"); end
      capture(bits, nv, spos, epos);
      n_checks++;
      if (nv != FL || spos != 0 || epos != FL - 1) begin
        n_fail++;
        $display("FAIL lsb_framing %h: valid=%0d start=%0d end=%0d expected %0d 0 %0d",
                 words[k], nv, spos, epos, FL, FL - 1);
      end
      n_checks++;
      if (bits[FL-1:0] !== exp_frame(words[k], 1'b0)) begin
        n_fail++;
        $display("FAIL lsb_bits %h: got %b expected %b", words[k], bits, exp_frame(words[k], 1'b0));
      end
      rx = '0;
      for (int i = 0; i < N; i++) rx = {rx[N-2:0], bits[i]};
      n_checks++;
      if (rx !== rxexp[k]) begin
        n_fail++;
        $display("FAIL lsb_left_receiver: got %h expected %h", rx, rxexp[k]);
      end
    end
  endtask

  task automatic test_msb_first;
    logic [N:0]   bits;
    logic [N-1:0] rx;
    int nv, spos, epos;
    bit ok;
    send_one(8'h81, 1'b1, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL msb_accept: in_ready never rose"); end
    capture(bits, nv, spos, epos);
    n_checks++;
    if (bits[N-1:0] !== 8'b1000_0001 || nv != FL || spos != 0 || epos != FL - 1) begin
      n_fail++;
      $display("FAIL msb_frame: bits=%b valid=%0d start=%0d end=%0d", bits, nv, spos, epos);
    end
    rx = '0;
    for (int i = 0; i < N; i++) rx = {bits[i], rx[N-1:1]};
    n_checks++;
    if (rx !== 8'h81) begin
      n_fail++;
      $display("FAIL msb_right_receiver: got %h expected 81", rx);
    end
  endtask

  task automatic test_random_frames;
    logic [N:0]   bits;
    logic [N-1:0] w;
    logic         m;
    int nv, spos, epos;
    bit ok;
    for (int k = 0; k < 6; k++) begin
      w = N'($urandom);
      m = 1'($urandom);
      send_one(w, m, ok);
      capture(bits, nv, spos, epos);
      n_checks++;
      if (!ok || nv != FL || spos != 0 || epos != FL - 1 || bits[FL-1:0] !== exp_frame(w, m)) begin
        n_fail++;
        $display("FAIL random_frame %h msb=%b: bits=%b expected %b valid=%0d start=%0d end=%0d",
                 w, m, bits, exp_frame(w, m), nv, spos, epos);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [N-1:0] wq[$];
    logic         mq[$];
    logic [N-1:0] w, ew;
    logic         m, em;
    logic [N:0]   cur;
    int pushed, frames, last_start, nb;
    int total;
    total = 8;
    pushed = 0;
    frames = 0;
    last_start = -1;
    nb = 0;
    cur = '0;
    for (int cyc = 0; cyc < 400 && frames < total; cyc++) begin
      @(negedge clk);
      if (bus.sdo_valid) begin
        if (bus.frame_start) begin
          if (last_start >= 0) begin
            n_checks++;
            if (cyc - last_start != FL + GAP + 1) begin
              n_fail++;
              $display("FAIL b2b_spacing: got %0d expected %0d", cyc - last_start, FL + GAP + 1);
            end
          end
          last_start = cyc;
          nb = 0;
          cur = '0;
        end
        if (nb <= N) cur[nb] = bus.sdo;
        nb++;
        if (bus.frame_end) begin
          n_checks++;
          if (wq.size() == 0) begin
            n_fail++;
            $display("FAIL b2b_extra_frame: got frame %b expected none", cur);
          end else begin
            ew = wq.pop_front();
            em = mq.pop_front();
            if (nb != FL || cur[FL-1:0] !== exp_frame(ew, em)) begin
              n_fail++;
              $display("FAIL b2b_frame %0d: got %b (%0d bits) expected %b", frames, cur, nb,
                       exp_frame(ew, em));
            end
          end
          frames++;
        end
      end
      if (bus.in_ready && pushed < total) begin
        w = (pushed == 0) ? 8'h0F : (pushed == 1) ? 8'hF0 : N'($urandom);
        m = (pushed < 2) ? 1'b0 : 1'($urandom);
        wq.push_back(w);
        mq.push_back(m);
        pushed++;
        bus.in_valid = 1'b1;
        bus.in_data = w;
        bus.in_msb_first = m;
      end else if (bus.in_ready) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_data = N'($urandom);
        bus.in_msb_first = 1'($urandom);
      end
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (frames != total) begin
      n_fail++;
      $display("FAIL b2b_frame_count: got %0d expected %0d", frames, total);
    end
    repeat (GAP + 3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [N:0] bits;
    int nv, spos, epos;
    bit ok;
    send_one(8'hFF, 1'($urandom), ok);
    repeat (4) @(negedge clk);
    n_checks++;
    if (!ok || bus.sdo_valid !== 1'b1 || bus.sdo !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_pre: sdo_valid=%b sdo=%b expected 1 1", bus.sdo_valid, bus.sdo);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if ({bus.sdo_valid, bus.sdo, bus.busy, bus.in_ready, bus.frame_end} !== 5'b0) begin
      n_fail++;
      $display("FAIL midrst_immediate: got %b expected 00000",
               {bus.sdo_valid, bus.sdo, bus.busy, bus.in_ready, bus.frame_end});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.sdo_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_release: in_ready=%b sdo_valid=%b expected 1 0", bus.in_ready, bus.sdo_valid);
    end
    send_one(8'h3C, 1'b0, ok);
    capture(bits, nv, spos, epos);
    n_checks++;
    if (!ok || nv != FL || spos != 0 || epos != FL - 1 || bits[FL-1:0] !== exp_frame(8'h3C, 1'b0)) begin
      n_fail++;
      $display("FAIL midrst_fresh_frame: bits=%b expected %b valid=%0d start=%0d end=%0d",
               bits, exp_frame(8'h3C, 1'b0), nv, spos, epos);
    end
  endtask

`ifdef PISO_PARITY_EN
  task automatic test_parity;
    logic [N-1:0] words [2];
    logic         pexp  [2];
    logic [N:0]   bits;
    int nv, spos, epos;
    bit ok;
    words = '{8'h07, 8'h03};
    pexp  = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      send_one(words[k], 1'b0, ok);
      capture(bits, nv, spos, epos);
      n_checks++;
      if (!ok || nv != N + 1 || epos != N || bits[N] !== pexp[k]) begin
        n_fail++;
        $display("FAIL parity %h: parity=%b expected %b valid=%0d end=%0d", words[k], bits[N],
                 pexp[k], nv, epos);
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_msb_first = 1'b0;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_random_frames();
    test_back_to_back();
    test_reset_mid_frame();
`ifdef PISO_PARITY_EN
    test_parity();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
